id_ex_stage: RTL

ID/EX pipeline register for the 5-stage core. It sits directly downstream of the ID-stage controller and register file, and registers their outputs for the EX stage: the ex/mem/wb control bundles, operands, immediate, register addresses and PC. It also detects load-use hazards, inserts bubbles, and applies branch flushes. A saturating counter records the number of load-use bubbles inserted.

---
 rtl/id_ex_stage_pkg.sv | 31 +++
 rtl/id_ex_stage_hazard_detect.sv | 43 ++++
 rtl/id_ex_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// ============================================================================
// Module : id_ex_stage_pkg
// Shared control-bundle layout and edge-action encoding for the ID/EX register.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package id_ex_stage_pkg;

  localparam int EX_CTRL_WIDTH  = 4;
  localparam int MEM_CTRL_WIDTH = 2;
  localparam int WB_CTRL_WIDTH  = 2;

  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;
  localparam int REG_WRITE = 0;
  localparam int MEM2REG   = 1;

  localparam int ZERO_REG = 0;

  typedef enum logic [2:0] {
    ACT_LOAD   = 3'd0,
    ACT_BUBBLE = 3'd1,
    ACT_HOLD   = 3'd2,
    ACT_STALL  = 3'd3,
    ACT_CLEAR  = 3'd4
  } edge_action_t;

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_hazard_detect.sv
// ============================================================================
// Module : id_ex_stage_hazard_detect
// Combinational load-use hazard detection against the load sitting in EX.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [RA_W-1:0] id_rs1_addr_i,
  input  logic [RA_W-1:0] id_rs2_addr_i,
  input  logic            id_uses_rs1_i,
  input  logic            id_uses_rs2_i,
  input  logic            ex_valid_i,
  input  logic            ex_mem_read_i,
  input  logic [RA_W-1:0] ex_rd_addr_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            haz_o,
  output logic            load_use_stall_o
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = id_uses_rs1_i & (ex_rd_addr_i == id_rs1_addr_i);
  assign w_rs2_match = id_uses_rs2_i & (ex_rd_addr_i == id_rs2_addr_i);

  assign haz_o = id_valid_i & ex_valid_i & ex_mem_read_i
               & (ex_rd_addr_i != RA_W'(ZERO_REG))
               & (w_rs1_match | w_rs2_match);

  // Reset gating keeps the stall defined before the EX registers are.
  assign load_use_stall_o = haz_o & ~flush_i & ~hold_i & ~rst_i;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// Module : id_ex_stage
// ID/EX pipeline register with load-use bubbling, flush, hold and bubble count.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [XLEN-1:0]           id_pc_i,
  input  logic [XLEN-1:0]           id_rs1_data_i,
  input  logic [XLEN-1:0]           id_rs2_data_i,
  input  logic [XLEN-1:0]           id_imm_i,
  input  logic [RA_W-1:0]           id_rs1_addr_i,
  input  logic [RA_W-1:0]           id_rs2_addr_i,
  input  logic [RA_W-1:0]           id_rd_addr_i,
  input  logic                      id_uses_rs1_i,
  input  logic                      id_uses_rs2_i,
  input  logic [EX_CTRL_WIDTH-1:0]  id_ex_ctrl_i,
  input  logic [MEM_CTRL_WIDTH-1:0] id_mem_ctrl_i,
  input  logic [WB_CTRL_WIDTH-1:0]  id_wb_ctrl_i,
  input  logic                      flush_i,
  input  logic                      hold_i,
  output logic                      load_use_stall_o,
  output logic                      ex_valid_o,
  output logic [XLEN-1:0]           ex_pc_o,
  output logic [XLEN-1:0]           ex_rs1_data_o,
  output logic [XLEN-1:0]           ex_rs2_data_o,
  output logic [XLEN-1:0]           ex_imm_o,
  output logic [RA_W-1:0]           ex_rs1_addr_o,
  output logic [RA_W-1:0]           ex_rs2_addr_o,
  output logic [RA_W-1:0]           ex_rd_addr_o,
  output logic [EX_CTRL_WIDTH-1:0]  ex_ctrl_o,
  output logic [MEM_CTRL_WIDTH-1:0] ex_mem_ctrl_o,
  output logic [WB_CTRL_WIDTH-1:0]  ex_wb_ctrl_o,
  output logic [CNT_W-1:0]          bubble_cnt_o
);

  logic                      r_valid;
  logic [XLEN-1:0]           r_pc;
  logic [XLEN-1:0]           r_rs1_data;
  logic [XLEN-1:0]           r_rs2_data;
  logic [XLEN-1:0]           r_imm;
  logic [RA_W-1:0]           r_rs1_addr;
  logic [RA_W-1:0]           r_rs2_addr;
  logic [RA_W-1:0]           r_rd_addr;
  logic [EX_CTRL_WIDTH-1:0]  r_ex_ctrl;
  logic [MEM_CTRL_WIDTH-1:0] r_mem_ctrl;
  logic [WB_CTRL_WIDTH-1:0]  r_wb_ctrl;
  logic [CNT_W-1:0]          r_bubble_cnt;

  logic         w_haz;
  edge_action_t w_action;

  id_ex_stage_hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard_detect (
    .rst_i            (rst_i),
    .id_valid_i       (id_valid_i),
    .id_rs1_addr_i    (id_rs1_addr_i),
    .id_rs2_addr_i    (id_rs2_addr_i),
    .id_uses_rs1_i    (id_uses_rs1_i),
    .id_uses_rs2_i    (id_uses_rs2_i),
    .ex_valid_i       (r_valid),
    .ex_mem_read_i    (r_mem_ctrl[MEM_READ]),
    .ex_rd_addr_i     (r_rd_addr),
    .flush_i          (flush_i),
    .hold_i           (hold_i),
    .haz_o            (w_haz),
    .load_use_stall_o (load_use_stall_o)
  );

  // Flush outranks hold so a resolved branch is never lost behind a stall.
  always_comb begin
    w_action = ACT_LOAD;
    if (rst_i)        w_action = ACT_CLEAR;
    else if (flush_i) w_action = ACT_BUBBLE;
    else if (hold_i)  w_action = ACT_HOLD;
    else if (w_haz)   w_action = ACT_STALL;
  end

  always_ff @(posedge clk_i) begin
    case (w_action)
      ACT_LOAD: begin
        r_valid    <= id_valid_i;
        r_pc       <= id_pc_i;
        r_rs1_data <= id_rs1_data_i;
        r_rs2_data <= id_rs2_data_i;
        r_imm      <= id_imm_i;
        r_rs1_addr <= id_rs1_addr_i;
        r_rs2_addr <= id_rs2_addr_i;
        r_rd_addr  <= id_rd_addr_i;
        r_ex_ctrl  <= id_valid_i ? id_ex_ctrl_i  : '0;
        r_mem_ctrl <= id_valid_i ? id_mem_ctrl_i : '0;
        r_wb_ctrl  <= id_valid_i ? id_wb_ctrl_i  : '0;
      end
      ACT_HOLD: ;
      default: begin
        r_valid    <= 1'b0;
        r_pc       <= '0;
        r_rs1_data <= '0;
        r_rs2_data <= '0;
        r_imm      <= '0;
        r_rs1_addr <= '0;
        r_rs2_addr <= '0;
        r_rd_addr  <= '0;
        r_ex_ctrl  <= '0;
        r_mem_ctrl <= '0;
        r_wb_ctrl  <= '0;
      end
    endcase

    if (w_action == ACT_CLEAR)
      r_bubble_cnt <= '0;
    else if (w_action == ACT_STALL && r_bubble_cnt != {CNT_W{1'b1}})
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
  end

  assign ex_valid_o    = r_valid;
  assign ex_pc_o       = r_pc;
  assign ex_rs1_data_o = r_rs1_data;
  assign ex_rs2_data_o = r_rs2_data;
  assign ex_imm_o      = r_imm;
  assign ex_rs1_addr_o = r_rs1_addr;
  assign ex_rs2_addr_o = r_rs2_addr;
  assign ex_rd_addr_o  = r_rd_addr;
  assign ex_ctrl_o     = r_ex_ctrl;
  assign ex_mem_ctrl_o = r_mem_ctrl;
  assign ex_wb_ctrl_o  = r_wb_ctrl;
  assign bubble_cnt_o  = r_bubble_cnt;

endmodule

`default_nettype wire
